// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engines: mode encodings, default width,
// width helpers and the shift-engine state type.
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    // SPI mode encoding is {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Edge counter must hold 0..2*dw.
    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(2 * dw + 1);
    endfunction

    // Frame length field must hold 0..dw.
    function automatic int unsigned len_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } spi_state_e;

endpackage

// File: rtl/spi_edge_decode.sv
// Maps raw sclk edge strobes to drive/sample strobes for the active SPI mode.
// Enforces lead/trail alternation via edge-count parity and drops coincident strobes.
module spi_edge_decode
    import spi_pkg::*;
(
    input  logic cpol,
    input  logic cpha,
    input  logic sclk_rise,
    input  logic sclk_fall,
    input  logic cnt_odd,
    output logic drive_stb,
    output logic sample_stb
);

    logic lead;
    logic trail;
    logic lead_ok;
    logic trail_ok;

    // Resolve lead/trail for the mode, then pick which one drives and which samples
    always_comb begin
        lead  = 1'b0;
        trail = 1'b0;
        unique case ({cpol, cpha})
            MODE0, MODE1: begin
                lead  = sclk_rise;
                trail = sclk_fall;
            end
            MODE2, MODE3: begin
                lead  = sclk_fall;
                trail = sclk_rise;
            end
            default: ;
        endcase
        // A lead is only valid at an even count, a trail only at an odd count;
        // rise and fall together cancel out.
        lead_ok    = lead & ~trail & ~cnt_odd;
        trail_ok   = trail & ~lead & cnt_odd;
        drive_stb  = cpha ? lead_ok : trail_ok;
        sample_stb = cpha ? trail_ok : lead_ok;
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Single-clock SPI master shift engine: serialises tx on mosi, deserialises miso,
// all four modes, MSB/LSB first, 1..DATA_WIDTH bit frames, rx buffer with ack/overrun.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CNT_W      = cnt_width(DATA_WIDTH)
) (
    input  logic                                 PCLK,
    input  logic                                 PRESETn,
    input  logic                                 ss,
    input  logic                                 start,
    input  logic                                 cpol,
    input  logic                                 cpha,
    input  logic                                 lsbfe,
    input  logic [len_width(DATA_WIDTH)-1:0]     frame_len,
    input  logic [DATA_WIDTH-1:0]                tx_data,
    input  logic                                 sclk_rise,
    input  logic                                 sclk_fall,
    input  logic                                 miso,
    input  logic                                 rx_ack,
    output logic                                 mosi,
    output logic                                 busy,
    output logic                                 done,
    output logic [DATA_WIDTH-1:0]                rx_data,
    output logic                                 rx_valid,
    output logic                                 rx_overrun
);

    localparam int unsigned LEN_W = len_width(DATA_WIDTH);

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsbfe_q, lsbfe_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_overrun_q, rx_overrun_d;

    logic                  drive_stb;
    logic                  sample_stb;
    logic                  edge_stb;
    logic                  last_edge;
    logic [LEN_W-1:0]      len_in;
    logic [LEN_W-1:0]      start_idx;
    logic                  first_bit;
    logic [CNT_W-1:0]      len_c;
    logic [CNT_W-1:0]      edge_inc;
    logic [CNT_W-1:0]      drive_k;
    logic [CNT_W-1:0]      tx_idx;
    logic [CNT_W-1:0]      sample_k;
    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] rx_next;

    spi_edge_decode u_edge_decode (
        .cpol       (cpol_q),
        .cpha       (cpha_q),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cnt_odd    (edge_cnt_q[0]),
        .drive_stb  (drive_stb),
        .sample_stb (sample_stb)
    );

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        lsbfe_d      = lsbfe_q;
        len_d        = len_q;
        edge_cnt_d   = edge_cnt_q;
        rx_shift_d   = rx_shift_q;
        mosi_d       = mosi_q;
        done_d       = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = 1'b0;

        // Out-of-range lengths (including 0) mean a full-width frame.
        len_in    = (frame_len == '0 || frame_len > LEN_W'(DATA_WIDTH)) ?
                    LEN_W'(DATA_WIDTH) : frame_len;
        start_idx = lsbfe ? '0 : (len_in - LEN_W'(1));
        first_bit = |(tx_data & (DATA_WIDTH'(1) << start_idx));

        edge_stb  = drive_stb | sample_stb;
        len_c     = CNT_W'(len_q);
        edge_inc  = edge_cnt_q + CNT_W'(1);
        last_edge = edge_stb && (edge_inc == (len_c << 1));

        // cpha=1 drives bit k on lead at count 2k; cpha=0 drives bit k+1 on trail at 2k+1.
        drive_k   = cpha_q ? (edge_cnt_q >> 1) : (edge_inc >> 1);
        tx_idx    = lsbfe_q ? drive_k : (len_c - CNT_W'(1) - drive_k);
        tx_bit    = |(tx_q & (DATA_WIDTH'(1) << tx_idx));
        sample_k  = edge_cnt_q >> 1;
        rx_next   = lsbfe_q ? (rx_shift_q | (DATA_WIDTH'(miso) << sample_k)) :
                              {rx_shift_q[DATA_WIDTH-2:0], miso};

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                mosi_d = 1'b0;
                if (start && !ss) begin
                    state_d    = StShift;
                    tx_d       = tx_data;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsbfe_d    = lsbfe;
                    len_d      = len_in;
                    edge_cnt_d = '0;
                    rx_shift_d = '0;
                    if (!cpha) begin
                        mosi_d = first_bit;
                    end
                end
            end
            StShift: begin
                if (ss) begin
                    state_d    = StIdle;
                    mosi_d     = 1'b0;
                    edge_cnt_d = '0;
                end else if (edge_stb) begin
                    edge_cnt_d = edge_inc;
                    if (sample_stb) begin
                        rx_shift_d = rx_next;
                    end
                    // The final trail in cpha=0 has no next bit: mosi holds.
                    if (drive_stb && !last_edge) begin
                        mosi_d = tx_bit;
                    end
                    if (last_edge) begin
                        state_d      = StIdle;
                        edge_cnt_d   = '0;
                        done_d       = 1'b1;
                        rx_data_d    = rx_shift_d;
                        rx_valid_d   = 1'b1;
                        rx_overrun_d = rx_valid_q & ~rx_ack;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= StIdle;
            tx_q         <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            lsbfe_q      <= 1'b0;
            len_q        <= '0;
            edge_cnt_q   <= '0;
            rx_shift_q   <= '0;
            mosi_q       <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            lsbfe_q      <= lsbfe_d;
            len_q        <= len_d;
            edge_cnt_q   <= edge_cnt_d;
            rx_shift_q   <= rx_shift_d;
            mosi_q       <= mosi_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign mosi       = mosi_q;
    assign busy       = (state_q == StShift);
    assign done       = done_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: a driver issues frames and pushes the
// expected result of each; a negedge monitor pops and checks on every done pulse.
module tb_spi_shift_engine;
    import spi_pkg::*;

    localparam int DW = 8;
    localparam int LW = $clog2(DW + 1);

    logic          PCLK;
    logic          PRESETn;
    logic          ss;
    logic          start;
    logic          cpol;
    logic          cpha;
    logic          lsbfe;
    logic [LW-1:0] frame_len;
    logic [DW-1:0] tx_data;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          miso;
    logic          rx_ack;
    logic          mosi;
    logic          busy;
    logic          done;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_overrun;

    logic          miso_drv;
    logic          loop_en;
    logic          sample_mark;

    assign miso = loop_en ? mosi : miso_drv;

    spi_shift_engine #(.DATA_WIDTH(DW)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .ss         (ss),
        .start      (start),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsbfe      (lsbfe),
        .frame_len  (frame_len),
        .tx_data    (tx_data),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .miso       (miso),
        .rx_ack     (rx_ack),
        .mosi       (mosi),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] bits;   // bits[k] = k-th bit expected on mosi
        int            len;
        logic          ovr;
    } exp_t;

    exp_t exp_q[$];
    bit   got_q[$];
    int   n_vec;
    int   n_miss;
    bit   model_valid;

    exp_t          mon_e;
    logic [DW-1:0] mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic bit_of(input logic [DW-1:0] w, input int k);
        return |(w & (DW'(1) << k));
    endfunction

    // Monitor: checks idle mosi, stray overrun, and each completed frame
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (!busy && !done) chk("mosi_idle", 32'(mosi), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(mon_e.rx));
                    chk("rx_valid", 32'(rx_valid), 32'd1);
                    chk("rx_overrun", 32'(rx_overrun), 32'(mon_e.ovr));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("mosi_bit_count", 32'(got_q.size()), 32'(mon_e.len));
                    mon_w = '0;
                    foreach (got_q[i]) mon_w = mon_w | (DW'(got_q[i]) << i);
                    chk("mosi_bits", 32'(mon_w), 32'(mon_e.bits));
                    chk("mosi_hold", 32'(mosi), 32'(bit_of(mon_e.bits, mon_e.len - 1)));
                end
            end else begin
                chk("overrun_stray", 32'(rx_overrun), 32'd0);
            end
            if (sample_mark) got_q.push_back(mosi);
            if (start && !ss && !busy) got_q.delete();
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((busy || done) && i < 64) begin
            tick();
            i++;
        end
        chk("idle_reached", 32'(busy | done), 32'd0);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("rx_valid_after_ack", 32'(rx_valid), 32'd0);
        model_valid = 1'b0;
    endtask

    // One strobe: lead = rise when cpol=0, fall when cpol=1; trail is the other.
    task automatic set_edge(input logic cp, input bit is_lead);
        if (is_lead ^ cp) sclk_rise = 1'b1;
        else sclk_fall = 1'b1;
    endtask

    // abort_mode: 0 none, 1 ss high before edge abort_at, 2 reset before edge abort_at
    task automatic run_frame(input logic [1:0] mode, input logic lf, input int flen,
                             input logic [DW-1:0] tx, input logic [DW-1:0] rw,
                             input bit loop, input int abort_mode, input int abort_at,
                             input bit stray, input bit ack_end, input bit mid_start,
                             input bit b2b, input bit pre_ack);
        logic          cp = mode[1];
        logic          ch = mode[0];
        int            eff = (flen == 0 || flen > DW) ? DW : flen;
        logic [DW-1:0] mask = DW'((DW'(1) << eff) - DW'(1));
        exp_t          e;
        bit            is_lead;
        int            k;

        if (!b2b) begin
            wait_idle();
            if (pre_ack) do_ack();
        end

        e.len  = eff;
        e.rx   = (loop ? tx : rw) & mask;
        e.ovr  = model_valid && !ack_end;
        e.bits = '0;
        for (int j = 0; j < eff; j++)
            e.bits = e.bits | (DW'(bit_of(tx, lf ? j : eff - 1 - j)) << j);
        if (abort_mode == 0) exp_q.push_back(e);

        ss        = 1'b0;
        cpol      = cp;
        cpha      = ch;
        lsbfe     = lf;
        frame_len = LW'(flen);
        tx_data   = tx;
        loop_en   = loop;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        // Inputs are latched at accept; scrambling them must not matter.
        tx_data   = DW'($urandom);
        cpol      = 1'($urandom);
        cpha      = 1'($urandom);
        lsbfe     = 1'($urandom);
        frame_len = LW'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);

        for (int ei = 0; ei < 2 * eff; ei++) begin
            is_lead = (ei % 2 == 0);
            if (abort_mode == 1 && ei == abort_at) begin
                ss = 1'b1;
                tick();
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_mosi", 32'(mosi), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_rx_valid", 32'(rx_valid), 32'(model_valid));
                ss = 1'b0;
                tick();
                loop_en = 1'b0;
                return;
            end
            if (abort_mode == 2 && ei == abort_at) begin
                PRESETn = 1'b0;
                #1;
                chk("rst_mosi", 32'(mosi), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_rx_data", 32'(rx_data), 32'd0);
                chk("rst_rx_valid", 32'(rx_valid), 32'd0);
                chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
                tick();
                PRESETn = 1'b1;
                tick();
                model_valid = 1'b0;
                loop_en = 1'b0;
                return;
            end
            for (int g = $urandom_range(1, 3); g > 0; g--) begin
                if (stray && ($urandom % 3 == 0)) begin
                    if ($urandom % 2 == 0) begin
                        sclk_rise = 1'b1;
                        sclk_fall = 1'b1;
                    end else begin
                        set_edge(cp, !is_lead);
                    end
                end
                if (mid_start && ei == 2 && g == 1) begin
                    start   = 1'b1;
                    tx_data = DW'($urandom);
                end
                tick();
                sclk_rise = 1'b0;
                sclk_fall = 1'b0;
                start     = 1'b0;
            end
            set_edge(cp, is_lead);
            if ((ch == 1'b0) == is_lead) begin
                k = ei / 2;
                miso_drv    = bit_of(rw, lf ? k : eff - 1 - k);
                sample_mark = 1'b1;
            end
            if (ei == 2 * eff - 1) begin
                chk("busy_before_last", 32'(busy), 32'd1);
                chk("done_before_last", 32'(done), 32'd0);
                if (ack_end) rx_ack = 1'b1;
            end
            tick();
            sclk_rise   = 1'b0;
            sclk_fall   = 1'b0;
            sample_mark = 1'b0;
            rx_ack      = 1'b0;
        end
        loop_en     = 1'b0;
        model_valid = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        model_valid = 1'b0;
        PRESETn     = 1'b0;
        ss          = 1'b1;
        start       = 1'b0;
        cpol        = 1'b0;
        cpha        = 1'b0;
        lsbfe       = 1'b0;
        frame_len   = '0;
        tx_data     = '0;
        sclk_rise   = 1'b0;
        sclk_fall   = 1'b0;
        rx_ack      = 1'b0;
        miso_drv    = 1'b0;
        loop_en     = 1'b0;
        sample_mark = 1'b0;
        tick();
        tick();
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_overrun", 32'(rx_overrun), 32'd0);
        PRESETn = 1'b1;
        ss      = 1'b0;
        tick();

        // mode, lf, flen, tx, rw, loop, abort, at, stray, ack_end, mid_start, b2b, pre_ack
        run_frame(MODE0, 1'b0, 8, 8'hA5, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(MODE3, 1'b1, 8, 8'h3C, 8'hC3, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(MODE1, 1'b0, 5, 8'hFB, 8'h0E, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(MODE2, 1'b0, 0, 8'h96, 8'h5A, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(MODE2, 1'b0, 0, 8'h17, 8'hE1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(MODE0, 1'b0, 8, 8'h81, 8'h7E, 1'b0, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(MODE0, 1'b0, 8, 8'hF0, 8'h0F, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame(MODE1, 1'b1, 6, 8'h2D, 8'h33, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(MODE3, 1'b0, 4, 8'h0B, 8'h06, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(MODE2, 1'b1, 8, 8'hC7, 8'h39, 1'b0, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] m   = 2'($urandom_range(0, 3));
            int         fl  = $urandom_range(0, 15);
            int         eff = (fl == 0 || fl > DW) ? DW : fl;
            bit         b2b = ($urandom % 4 == 0);
            bit         ab  = ($urandom % 10 == 0);
            run_frame(m, 1'($urandom), fl, DW'($urandom), DW'($urandom),
                      ($urandom % 4 == 0), ab ? 1 : 0, $urandom_range(0, 2 * eff - 1),
                      1'($urandom), ($urandom % 6 == 0), ($urandom % 5 == 0),
                      b2b, !b2b && ($urandom % 2 == 0));
        end

        wait_idle();
        tick();
        tick();
        tick();
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
